custom_result_stage: RTL and testbench

CUSTOM_RESULT_STAGE -- requirements
Module: custom_result_stage

---
 rtl/custom_result_stage.sv | 111 +++++++++++
 tb/tb_custom_result_stage.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/custom_result_stage.sv
// Result FIFO between an execute stage and the X-IF result channel.
// Optional combinational bypass on an empty FIFO: define CUSTOM_RESULT_BYPASS_EN.
module custom_result_stage #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned ID_WIDTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       ex_valid_i,
    input  logic [31:0]                ex_data_i,
    input  logic [4:0]                 ex_rd_i,
    input  logic [ID_WIDTH-1:0]        ex_id_i,
    output logic                       ex_ready_o,
    output logic                       result_valid_o,
    input  logic                       result_ready_i,
    output logic [31:0]                result_data_o,
    output logic [4:0]                 result_rd_o,
    output logic [ID_WIDTH-1:0]        result_id_o,
    output logic                       result_we_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       overflow_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [ID_WIDTH-1:0] id;
        logic [31:0]         data;
        logic [4:0]          rd;
    } entry_t;

    entry_t          mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            overflow;
    logic            fifo_empty;
    logic            bypass_take;
    logic            push;
    logic            pop;
    entry_t          out_entry;
    logic            out_valid;

    assign fifo_empty = (count == '0);
    assign ex_ready_o = (count != CW'(DEPTH));

    always_comb begin
        out_entry = '0;
        out_valid = 1'b0;
        if (!fifo_empty) begin
            out_entry = mem[rd_ptr];
            out_valid = 1'b1;
        end
`ifdef CUSTOM_RESULT_BYPASS_EN
        else if (ex_valid_i) begin
            out_entry.id   = ex_id_i;
            out_entry.data = ex_data_i;
            out_entry.rd   = ex_rd_i;
            out_valid      = 1'b1;
        end
`endif
    end

`ifdef CUSTOM_RESULT_BYPASS_EN
    // A bypassed result accepted this cycle never enters the FIFO.
    assign bypass_take = fifo_empty && ex_valid_i && result_ready_i;
`else
    assign bypass_take = 1'b0;
`endif

    assign push = ex_valid_i && ex_ready_o && !bypass_take;
    assign pop  = out_valid && result_ready_i && !fifo_empty;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= '{id: ex_id_i, data: ex_data_i, rd: ex_rd_i};
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (ex_valid_i && !ex_ready_o) begin
                overflow <= 1'b1;
            end
        end
    end

    assign result_valid_o = out_valid;
    assign result_data_o  = out_entry.data;
    assign result_rd_o    = out_entry.rd;
    assign result_id_o    = out_entry.id;
    assign result_we_o    = out_valid && (out_entry.rd != 5'd0);
    assign count_o        = count;
    assign overflow_o     = overflow;

endmodule

// File: tb/tb_custom_result_stage.sv
// Directed self-checking bench for custom_result_stage (default build, DEPTH=4).
module tb_custom_result_stage;

  logic        clk;
  logic        rst_n;
  logic        ex_valid;
  logic [31:0] ex_data;
  logic [4:0]  ex_rd;
  logic [3:0]  ex_id;
  logic        ex_ready;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic [4:0]  res_rd;
  logic [3:0]  res_id;
  logic        res_we;
  logic [2:0]  count;
  logic        overflow;

  int n_cmp = 0;
  int n_err = 0;

  custom_result_stage #(.DEPTH(4), .ID_WIDTH(4)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .ex_valid_i     (ex_valid),
    .ex_data_i      (ex_data),
    .ex_rd_i        (ex_rd),
    .ex_id_i        (ex_id),
    .ex_ready_o     (ex_ready),
    .result_valid_o (res_valid),
    .result_ready_i (res_ready),
    .result_data_o  (res_data),
    .result_rd_o    (res_rd),
    .result_id_o    (res_id),
    .result_we_o    (res_we),
    .count_o        (count),
    .overflow_o     (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic [4:0] r, input logic [3:0] i);
    ex_valid = v;
    ex_data  = d;
    ex_rd    = r;
    ex_id    = i;
  endtask

  task automatic fail(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_err++;
    $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    rst_n     = 1'b0;
    res_ready = 1'b0;
    drive(1'b0, 32'h0, 5'd0, 4'd0);
    #1;
    n_cmp++; if (count !== 3'd0) fail("reset_count", 32'(count), 32'd0);
    n_cmp++; if (ex_ready !== 1'b1) fail("reset_ready", 32'(ex_ready), 32'd1);
    n_cmp++; if (res_valid !== 1'b0) fail("reset_valid", 32'(res_valid), 32'd0);
    n_cmp++; if (res_data !== 32'h0) fail("reset_data", res_data, 32'h0);
    n_cmp++; if (overflow !== 1'b0) fail("reset_overflow", 32'(overflow), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    res_ready = 1'b1;
    drive(1'b1, 32'h0000_0005, 5'd10, 4'd3);
    #1;
    n_cmp++; if (res_valid !== 1'b0) fail("single_no_bypass", 32'(res_valid), 32'd0);
    tick();
    drive(1'b0, 32'h0, 5'd0, 4'd0);
    #1;
    n_cmp++; if (res_valid !== 1'b1) fail("single_valid", 32'(res_valid), 32'd1);
    n_cmp++; if (res_data !== 32'h5) fail("single_data", res_data, 32'h5);
    n_cmp++; if (res_rd !== 5'd10) fail("single_rd", 32'(res_rd), 32'd10);
    n_cmp++; if (res_id !== 4'd3) fail("single_id", 32'(res_id), 32'd3);
    n_cmp++; if (res_we !== 1'b1) fail("single_we", 32'(res_we), 32'd1);
    n_cmp++; if (count !== 3'd1) fail("single_count", 32'(count), 32'd1);
    tick();
    n_cmp++; if (res_valid !== 1'b0) fail("single_done_valid", 32'(res_valid), 32'd0);
    n_cmp++; if (count !== 3'd0) fail("single_done_count", 32'(count), 32'd0);
    n_cmp++; if (res_data !== 32'h0) fail("single_done_data", res_data, 32'h0);
    n_cmp++; if (res_we !== 1'b0) fail("single_done_we", 32'(res_we), 32'd0);

    res_ready = 1'b0;
    drive(1'b1, 32'h1F, 5'd0, 4'd1);
    tick();
    drive(1'b0, 32'h0, 5'd0, 4'd0);
    #1;
    n_cmp++; if (res_valid !== 1'b1) fail("rd0_valid", 32'(res_valid), 32'd1);
    n_cmp++; if (res_we !== 1'b0) fail("rd0_we", 32'(res_we), 32'd0);
    n_cmp++; if (res_data !== 32'h1F) fail("rd0_data", res_data, 32'h1F);
    res_ready = 1'b1;
    tick();
    n_cmp++; if (count !== 3'd0) fail("rd0_drained", 32'(count), 32'd0);

    res_ready = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      drive(1'b1, 32'h100 + 32'(i), 5'(i + 1), 4'(i));
      tick();
    end
    n_cmp++; if (count !== 3'd4) fail("full_count", 32'(count), 32'd4);
    n_cmp++; if (ex_ready !== 1'b0) fail("full_ready", 32'(ex_ready), 32'd0);
    n_cmp++; if (overflow !== 1'b0) fail("full_no_overflow", 32'(overflow), 32'd0);
    drive(1'b1, 32'hDEAD, 5'd9, 4'd4);
    tick();
    drive(1'b0, 32'h0, 5'd0, 4'd0);
    #1;
    n_cmp++; if (overflow !== 1'b1) fail("overflow_set", 32'(overflow), 32'd1);
    n_cmp++; if (count !== 3'd4) fail("overflow_count", 32'(count), 32'd4);
    res_ready = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      n_cmp++; if (res_valid !== 1'b1) fail("bp_valid", 32'(res_valid), 32'd1);
      n_cmp++; if (res_id !== 4'(i)) fail("bp_id", 32'(res_id), 32'(i));
      n_cmp++; if (res_data !== 32'h100 + 32'(i)) fail("bp_data", res_data, 32'h100 + 32'(i));
      tick();
    end
    n_cmp++; if (count !== 3'd0) fail("bp_empty", 32'(count), 32'd0);
    n_cmp++; if (res_valid !== 1'b0) fail("bp_empty_valid", 32'(res_valid), 32'd0);
    n_cmp++; if (overflow !== 1'b1) fail("overflow_sticky", 32'(overflow), 32'd1);

    res_ready = 1'b0;
    for (int unsigned k = 0; k < 2; k++) begin
      drive(1'b1, 32'h200 + 32'(k), 5'd1, 4'(k));
      tick();
    end
    n_cmp++; if (count !== 3'd2) fail("pp_start_count", 32'(count), 32'd2);
    res_ready = 1'b1;
    for (int unsigned k = 0; k < 10; k++) begin
      drive(1'b1, 32'h200 + 32'(k + 2), 5'd1, 4'(k + 2));
      #1;
      n_cmp++; if (res_data !== 32'h200 + 32'(k)) fail("pp_data", res_data, 32'h200 + 32'(k));
      n_cmp++; if (res_id !== 4'(k)) fail("pp_id", 32'(res_id), 32'(4'(k)));
      tick();
      n_cmp++; if (count !== 3'd2) fail("pp_count", 32'(count), 32'd2);
    end
    drive(1'b0, 32'h0, 5'd0, 4'd0);
    #1;
    n_cmp++; if (res_data !== 32'h20A) fail("pp_tail0", res_data, 32'h20A);
    tick();
    n_cmp++; if (res_data !== 32'h20B) fail("pp_tail1", res_data, 32'h20B);
    tick();
    n_cmp++; if (count !== 3'd0) fail("pp_drained", 32'(count), 32'd0);

    res_ready = 1'b0;
    drive(1'b1, 32'hABCD, 5'd7, 4'd5);
    tick();
    drive(1'b0, 32'h0, 5'd0, 4'd0);
    for (int unsigned c = 0; c < 5; c++) begin
      n_cmp++; if (res_valid !== 1'b1) fail("stable_valid", 32'(res_valid), 32'd1);
      n_cmp++; if (res_data !== 32'hABCD) fail("stable_data", res_data, 32'hABCD);
      n_cmp++; if (res_rd !== 5'd7) fail("stable_rd", 32'(res_rd), 32'd7);
      n_cmp++; if (res_id !== 4'd5) fail("stable_id", 32'(res_id), 32'd5);
      tick();
    end

    drive(1'b1, 32'h6, 5'd6, 4'd6);
    tick();
    drive(1'b1, 32'h7, 5'd7, 4'd7);
    tick();
    drive(1'b0, 32'h0, 5'd0, 4'd0);
    #1;
    n_cmp++; if (count !== 3'd3) fail("prereset_count", 32'(count), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (count !== 3'd0) fail("rst_count", 32'(count), 32'd0);
    n_cmp++; if (res_valid !== 1'b0) fail("rst_valid", 32'(res_valid), 32'd0);
    n_cmp++; if (overflow !== 1'b0) fail("rst_overflow", 32'(overflow), 32'd0);
    n_cmp++; if (ex_ready !== 1'b1) fail("rst_ready", 32'(ex_ready), 32'd1);
    n_cmp++; if (res_data !== 32'h0) fail("rst_data", res_data, 32'h0);
    tick();
    rst_n = 1'b1;
    res_ready = 1'b1;
    for (int unsigned c = 0; c < 3; c++) begin
      tick();
      n_cmp++; if (res_valid !== 1'b0) fail("post_rst_valid", 32'(res_valid), 32'd0);
      n_cmp++; if (count !== 3'd0) fail("post_rst_count", 32'(count), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
